sprite_palette_engine: RTL
==========================

// Module: sprite_palette_engine
// PURPOSE
//  Writable, multi-bank sprite colour lookup with 2-stage registered pipeline.
//  Maps per-pixel palette index plus bank select to RGB, with fade and flash modes.
//  Flags a colour-key (transparent) index. Sits between sprite ROM index fetch and VGA colour mux.
//  Replaces fixed per-sprite combinational palettes; one instance serves all sprites.
// PARAMETERS
//  IDX_W        4   palette index width; ENTRIES = 2**IDX_W per bank
//  NUM_PAL      4   number of palette banks; PAL_W = max(1,$clog2(NUM_PAL))
//  CH_W         4   bits per colour channel; RGB word = 3*CH_W, packed {R,G,B}
//  TRANSP_IDX   0   index reported as transparent
//  FLASH_FRAMES 8   frames per flash phase (>=1)
// PORTS
//  Clk         in   1          system clock, all state on rising edge
//  Reset       in   1          asynchronous, active-high
//  wr_en       in   1          write palette entry this cycle
//  wr_pal      in   PAL_W      bank to write
//  wr_idx      in   IDX_W      entry to write
//  wr_rgb      in   3*CH_W     {R,G,B} to store
//  frame_start in   1          1-cycle pulse per video frame (vsync edge)
//  mode        in   2          0 normal, 1 fade, 2 flash, 3 = normal
//  fade_lvl    in   CH_W+1     brightness 0..2**CH_W; larger values clamp to 2**CH_W
//  in_valid    in   1          pixel lookup request
//  pal_sel     in   PAL_W      bank for this pixel
//  pix_index   in   IDX_W      index for this pixel
//  out_valid   out  1          result valid
//  red,green,blue out CH_W     output colour
//  out_transp  out  1          pixel index == TRANSP_IDX
// BEHAVIOUR
//  Reset: all palette entries 12'h000 (all-zero RGB); out_valid, out_transp, red/green/blue = 0;
//   frame counter 0; flash_phase 0. Reset asserted mid-stream kills in-flight pixels at once.
//  Storage: NUM_PAL x ENTRIES registers of 3*CH_W. Write lands on the edge where wr_en=1.
//   Out-of-range wr_pal (>=NUM_PAL) ignored. Out-of-range pal_sel: lookup returns 0, transp still computed.
//  Pipeline, no backpressure: request at edge t -> result at edge t+2; out_valid = in_valid delayed 2.
//   S1 (edge t+1): register looked-up RGB, index-match flag, valid.
//   S2 (edge t+2): apply mode using mode/fade_lvl/flash_phase sampled at t+1; register outputs.
//  Read/write same entry same cycle: read returns OLD contents; new value visible to requests from t+1 on.
//  When out_valid=0, red/green/blue/out_transp hold previous values.
//  Fade (mode 1): ch_out = (ch * f) >> CH_W per channel, f = min(fade_lvl, 2**CH_W);
//   product width 2*CH_W+1, truncating; f=2**CH_W is identity, f=0 gives black.
//  Flash: counter increments on frame_start; at FLASH_FRAMES-1 it wraps to 0 and toggles flash_phase.
//   Counter runs in every mode. Mode 2 with flash_phase=1 outputs all channels = 2**CH_W-1;
//   flash_phase=0 outputs palette colour unchanged.
//  out_transp = (pix_index == TRANSP_IDX) registered through both stages, independent of mode;
//   RGB still driven with the computed colour.
//  frame_start simultaneous with in_valid: both processed; phase change affects pixels whose S2 is after it.
// TESTING
//  After Reset, lookup bank 0 idx 5 -> out_valid at +2 cycles, RGB 000, out_transp 0.
//  Write bank1 idx3 = 12'h4_6_E, then lookup bank1 idx3 mode0 -> red 4, green 6, blue E exactly 2 cycles later.
//  Same-cycle write 12'hFFF and read of bank0 idx2 (old 12'h123) -> 12'h123; next-cycle read -> 12'hFFF.
//  Mode1, entry 12'hF8_4: fade 16 -> F,8,4; fade 8 -> 7,4,2; fade 0 -> 0,0,0; fade 31 -> F,8,4.
//  Mode2, FLASH_FRAMES=8: 8 frame_start pulses -> output FFF; 8 more -> palette colour again.
//  Lookup idx 0 -> out_transp 1; streaming back-to-back valid for 16 cycles, Reset mid-burst -> out_valid 0 immediately.

Source files
------------

// File: rtl/sprite_palette_engine_if.sv
// Pixel lookup / palette write bundle for sprite_palette_engine.
//   master: drives palette writes, frame pulses, mode controls and pixel requests.
//   slave : returns out_valid, red/green/blue and out_transp.
interface sprite_palette_engine_if #(
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned NUM_PAL = 4,
  parameter int unsigned CH_W    = 4
);
  localparam int unsigned PAL_W = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;

  logic                wr_en;
  logic [PAL_W-1:0]    wr_pal;
  logic [IDX_W-1:0]    wr_idx;
  logic [3*CH_W-1:0]   wr_rgb;
  logic                frame_start;
  logic [1:0]          mode;
  logic [CH_W:0]       fade_lvl;
  logic                in_valid;
  logic [PAL_W-1:0]    pal_sel;
  logic [IDX_W-1:0]    pix_index;
  logic                out_valid;
  logic [CH_W-1:0]     red;
  logic [CH_W-1:0]     green;
  logic [CH_W-1:0]     blue;
  logic                out_transp;

  modport master (
    output wr_en, wr_pal, wr_idx, wr_rgb, frame_start, mode, fade_lvl,
    output in_valid, pal_sel, pix_index,
    input  out_valid, red, green, blue, out_transp
  );

  modport slave (
    input  wr_en, wr_pal, wr_idx, wr_rgb, frame_start, mode, fade_lvl,
    input  in_valid, pal_sel, pix_index,
    output out_valid, red, green, blue, out_transp
  );
endinterface

// File: rtl/sprite_palette_engine.sv
// Writable multi-bank sprite palette with a 2-stage pipeline and fade/flash modes.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - sprite_palette_engine_if.slave: palette writes, frame pulse, mode/fade
//          controls, pixel request (in_valid/pal_sel/pix_index) and the registered
//          colour result (out_valid/red/green/blue/out_transp), 2 cycles after request.
module sprite_palette_engine #(
  parameter int unsigned IDX_W        = 4,
  parameter int unsigned NUM_PAL      = 4,
  parameter int unsigned CH_W         = 4,
  parameter int unsigned TRANSP_IDX   = 0,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input logic                    clk,
  input logic                    rst,
  sprite_palette_engine_if.slave bus
);
  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam int unsigned PAL_W   = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;
  localparam int unsigned RGB_W   = 3 * CH_W;
  localparam int unsigned CNT_W   = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int unsigned PROD_W  = 2 * CH_W + 1;
  localparam int unsigned FULL    = 2 ** CH_W;

  logic [RGB_W-1:0] mem_q [NUM_PAL][ENTRIES];
  logic [RGB_W-1:0] rd_rgb;

  logic [CNT_W-1:0] frame_cnt_q;
  logic             flash_phase_q;

  logic             s1_valid_q;
  logic [RGB_W-1:0] s1_rgb_q;
  logic             s1_transp_q;

  logic [CH_W:0]    fade_f;
  logic [PROD_W-1:0] prod [3];
  logic [RGB_W-1:0] faded;
  logic [RGB_W-1:0] s2_rgb;

  logic             out_valid_q;
  logic [CH_W-1:0]  red_q, green_q, blue_q;
  logic             out_transp_q;

  // Palette storage; banks >= NUM_PAL never match so their writes are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned p = 0; p < NUM_PAL; p++) begin
        for (int unsigned e = 0; e < ENTRIES; e++) begin
          mem_q[p][e] <= '0;
        end
      end
    end else begin
      for (int unsigned p = 0; p < NUM_PAL; p++) begin
        for (int unsigned e = 0; e < ENTRIES; e++) begin
          if (bus.wr_en && bus.wr_pal == PAL_W'(p) && bus.wr_idx == IDX_W'(e)) begin
            mem_q[p][e] <= bus.wr_rgb;
          end
        end
      end
    end
  end

  // Read sees pre-write contents; out-of-range bank reads as black.
  always_comb begin
    rd_rgb = '0;
    for (int unsigned p = 0; p < NUM_PAL; p++) begin
      if (bus.pal_sel == PAL_W'(p)) rd_rgb = mem_q[p][bus.pix_index];
    end
  end

  // Frame counter runs regardless of mode so flash timing stays frame-locked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q   <= '0;
      flash_phase_q <= 1'b0;
    end else if (bus.frame_start) begin
      if (frame_cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
        frame_cnt_q   <= '0;
        flash_phase_q <= ~flash_phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: lookup result, key match and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_rgb_q    <= '0;
      s1_transp_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_rgb_q    <= rd_rgb;
        s1_transp_q <= (bus.pix_index == IDX_W'(TRANSP_IDX));
      end
    end
  end

  // Fade: (ch * min(fade_lvl, 2**CH_W)) >> CH_W, truncated to CH_W bits.
  always_comb begin
    fade_f = (bus.fade_lvl > (CH_W + 1)'(FULL)) ? (CH_W + 1)'(FULL) : bus.fade_lvl;
    faded  = '0;
    for (int c = 0; c < 3; c++) begin
      prod[c] = PROD_W'(s1_rgb_q[c*CH_W +: CH_W]) * PROD_W'(fade_f);
      faded[c*CH_W +: CH_W] = prod[c][CH_W +: CH_W];
    end
  end

  always_comb begin
    s2_rgb = s1_rgb_q;
    case (bus.mode)
      2'd1:    s2_rgb = faded;
      2'd2:    if (flash_phase_q) s2_rgb = '1;
      default: s2_rgb = s1_rgb_q;
    endcase
  end

  // Stage 2: colour outputs only update on a valid pixel, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      out_transp_q <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        red_q        <= s2_rgb[2*CH_W +: CH_W];
        green_q      <= s2_rgb[CH_W +: CH_W];
        blue_q       <= s2_rgb[0 +: CH_W];
        out_transp_q <= s1_transp_q;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.red        = red_q;
  assign bus.green      = green_q;
  assign bus.blue       = blue_q;
  assign bus.out_transp = out_transp_q;
endmodule
